// File: rtl/alu_share_arb_pkg.sv
// Shared RISC-V ALU types: the alu_t operation encoding and a legality helper
// used by anything that routes ops into the ALU.
package riscv_types;

  localparam int XLEN = 32;

  typedef enum logic [3:0] {
    ADD  = 4'd0,
    SUB  = 4'd1,
    SLL  = 4'd2,
    SLT  = 4'd3,
    SLTU = 4'd4,
    XOR  = 4'd5,
    SRL  = 4'd6,
    SRA  = 4'd7,
    OR   = 4'd8,
    AND  = 4'd9
  } alu_t;

  function automatic bit alu_op_legal(alu_t op);
    case (op)
      ADD, SUB, SLT, SLTU, SLL, SRL, SRA, XOR, AND, OR: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_share_arb_if.sv
// Request/response bundle between NUM_REQ requesters (master) and the shared
// ALU arbiter (slave).
interface alu_share_arb_if #(parameter int NUM_REQ = 2);
  import riscv_types::*;

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_ready;
  alu_t                          req_op [NUM_REQ];
  logic [NUM_REQ-1:0][XLEN-1:0]  req_a;
  logic [NUM_REQ-1:0][XLEN-1:0]  req_b;
  logic [NUM_REQ-1:0]            rsp_valid;
  logic [NUM_REQ-1:0]            rsp_ready;
  logic [NUM_REQ-1:0][XLEN-1:0]  rsp_result;
  logic [NUM_REQ-1:0]            rsp_zero;
  logic [NUM_REQ-1:0]            rsp_err;
  logic                          busy;

  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_zero, rsp_err, busy
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_zero, rsp_err, busy
  );

endinterface

// File: rtl/alu.sv
// Purely combinational 32-bit integer ALU; shifts use b[4:0], compares
// return 0/1 zero-extended, unknown encodings produce zero.
module alu
  import riscv_types::*;
(
  input  alu_t            op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] result
);

  always_comb begin
    result = 32'h0;
    case (op)
      ADD:     result = a + b;
      SUB:     result = a - b;
      SLT:     result = ($signed(a) < $signed(b)) ? 32'h1 : 32'h0;
      SLTU:    result = (a < b) ? 32'h1 : 32'h0;
      SLL:     result = a << b[4:0];
      SRL:     result = a >> b[4:0];
      SRA:     result = $unsigned($signed(a) >>> b[4:0]);
      XOR:     result = a ^ b;
      AND:     result = a & b;
      OR:      result = a | b;
      default: result = 32'h0;
    endcase
  end

endmodule

// File: rtl/alu_share_arb_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first request at or after the
// pointer; the pointer moves past the winner only when advance is strobed.
module rr_arbiter #(
  parameter int N     = 2,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [N-1:0]     req,
  input  logic             advance,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx
);

  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic             found_s;
  int               idx_s;

  // Wrapping search starting at the priority pointer
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found_s   = 1'b0;
    idx_s     = 0;
    for (int k = 0; k < N; k++) begin
      idx_s = (int'(ptr_q) + k) % N;
      if (!found_s && req[idx_s]) begin
        found_s      = 1'b1;
        grant[idx_s] = 1'b1;
        grant_idx    = IDX_W'(idx_s);
      end else begin
        found_s = found_s;
      end
    end
  end

  always_comb begin
    if (advance) begin
      ptr_d = (grant_idx == IDX_W'(N - 1)) ? '0 : grant_idx + IDX_W'(1);
    end else begin
      ptr_d = ptr_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/alu_share_arb.sv
// Shares one ALU among NUM_REQ requesters with round-robin arbitration and a
// one-entry registered response buffer per requester.
module alu_share_arb
  import riscv_types::*;
#(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic              clk,
  input  logic              reset_n,
  alu_share_arb_if.slave    bus
);

  logic [NUM_REQ-1:0]           eligible_s;
  logic [NUM_REQ-1:0]           grant_s;
  logic [IDX_W-1:0]             grant_idx_s;
  logic                         grant_any_s;
  alu_t                         alu_op_s;
  logic [XLEN-1:0]              alu_a_s, alu_b_s, alu_res_s, buf_res_s;
  logic                         op_legal_s, buf_zero_s, buf_err_s;

  logic [NUM_REQ-1:0]           rsp_valid_q, rsp_valid_d;
  logic [NUM_REQ-1:0][XLEN-1:0] rsp_result_q, rsp_result_d;
  logic [NUM_REQ-1:0]           rsp_zero_q, rsp_zero_d;
  logic [NUM_REQ-1:0]           rsp_err_q, rsp_err_d;

  // A requester competes only if its buffer is empty or being drained now
  always_comb begin
    eligible_s = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      eligible_s[i] = bus.req_valid[i] & (~rsp_valid_q[i] | bus.rsp_ready[i]);
    end
  end

  assign grant_any_s = |grant_s;

  rr_arbiter #(.N(NUM_REQ), .IDX_W(IDX_W)) u_arb (
    .clk       (clk),
    .reset_n   (reset_n),
    .req       (eligible_s),
    .advance   (grant_any_s),
    .grant     (grant_s),
    .grant_idx (grant_idx_s)
  );

  always_comb begin
    alu_op_s = ADD;
    alu_a_s  = 32'h0;
    alu_b_s  = 32'h0;
    if (grant_any_s) begin
      alu_op_s = bus.req_op[grant_idx_s];
      alu_a_s  = bus.req_a[grant_idx_s];
      alu_b_s  = bus.req_b[grant_idx_s];
    end else begin
      alu_op_s = ADD;
    end
  end

  alu u_alu (
    .op     (alu_op_s),
    .a      (alu_a_s),
    .b      (alu_b_s),
    .result (alu_res_s)
  );

  // Illegal ops are masked here so the ALU's default output never gets buffered
  always_comb begin
    op_legal_s = alu_op_legal(alu_op_s);
    buf_res_s  = op_legal_s ? alu_res_s : 32'h0;
    buf_zero_s = op_legal_s ? (alu_res_s == 32'h0) : 1'b1;
    buf_err_s  = ~op_legal_s;
  end

  always_comb begin
    rsp_valid_d  = rsp_valid_q;
    rsp_result_d = rsp_result_q;
    rsp_zero_d   = rsp_zero_q;
    rsp_err_d    = rsp_err_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_s[i]) begin
        rsp_valid_d[i]  = 1'b1;
        rsp_result_d[i] = buf_res_s;
        rsp_zero_d[i]   = buf_zero_s;
        rsp_err_d[i]    = buf_err_s;
      end else if (rsp_valid_q[i] && bus.rsp_ready[i]) begin
        rsp_valid_d[i] = 1'b0;
      end else begin
        rsp_valid_d[i] = rsp_valid_q[i];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rsp_valid_q  <= '0;
      rsp_result_q <= '0;
      rsp_zero_q   <= '0;
      rsp_err_q    <= '0;
    end else begin
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
      rsp_zero_q   <= rsp_zero_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

  assign bus.req_ready  = grant_s;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_result = rsp_result_q;
  assign bus.rsp_zero   = rsp_zero_q;
  assign bus.rsp_err    = rsp_err_q;
  assign bus.busy       = (|rsp_valid_q) | (|bus.req_valid);

endmodule

// File: tb/tb_alu_share_arb.sv
// Scoreboard bench for alu_share_arb: stimulus queues expected responses,
// a negedge monitor pops and compares on every response handshake.
module tb_alu_share_arb;
  import riscv_types::*;

  typedef struct packed {
    logic [31:0] res;
    logic        zero;
    logic        err;
  } exp_t;

  localparam exp_t NONE = '0;

  logic clk = 1'b0;
  logic reset_n;
  int   n_chk  = 0;
  int   n_pass = 0;
  exp_t q0[$];
  exp_t q1[$];

  alu_share_arb_if #(.NUM_REQ(2)) bus();

  alu_share_arb #(.NUM_REQ(2)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(input logic [31:0] r, input logic z, input logic e);
    exp_t x;
    x.res  = r;
    x.zero = z;
    x.err  = e;
    return x;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic pop_check(input int i);
    exp_t e;
    int   sz;
    sz = (i == 0) ? q0.size() : q1.size();
    if (sz == 0) begin
      chk($sformatf("rsp%0d unexpected (queue depth)", i), 32'(sz), 32'd1);
    end else begin
      if (i == 0) e = q0.pop_front();
      else        e = q1.pop_front();
      chk($sformatf("rsp%0d result", i), bus.rsp_result[i], e.res);
      chk($sformatf("rsp%0d zero", i), 32'(bus.rsp_zero[i]), 32'(e.zero));
      chk($sformatf("rsp%0d err", i), 32'(bus.rsp_err[i]), 32'(e.err));
    end
  endtask

  // Monitor: every response handshake must match the oldest expectation
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (reset_n === 1'b1 && bus.rsp_valid[i] && bus.rsp_ready[i]) pop_check(i);
    end
  end

  // One cycle of stimulus; called at posedge+1, returns at next posedge+1
  task automatic cyc(input string name, input logic [1:0] v, input logic [1:0] rr,
                     input alu_t op0, input logic [31:0] a0, input logic [31:0] b0,
                     input alu_t op1, input logic [31:0] a1, input logic [31:0] b1,
                     input logic [1:0] exp_rdy, input exp_t e0, input exp_t e1);
    bus.req_valid = v;
    bus.rsp_ready = rr;
    bus.req_op[0] = op0;
    bus.req_a[0]  = a0;
    bus.req_b[0]  = b0;
    bus.req_op[1] = op1;
    bus.req_a[1]  = a1;
    bus.req_b[1]  = b1;
    @(negedge clk);
    #1;
    chk({name, " req_ready"}, 32'(bus.req_ready), 32'(exp_rdy));
    if (exp_rdy[0]) q0.push_back(e0);
    if (exp_rdy[1]) q1.push_back(e1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n       = 1'b0;
    bus.req_valid = 2'b00;
    bus.rsp_ready = 2'b00;
    bus.req_op[0] = ADD;
    bus.req_op[1] = ADD;
    bus.req_a     = '0;
    bus.req_b     = '0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    #1;
    chk("reset rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("reset result0", bus.rsp_result[0], 32'h0);
    chk("reset result1", bus.rsp_result[1], 32'h0);
    chk("reset zero", 32'(bus.rsp_zero), 32'd0);
    chk("reset err", 32'(bus.rsp_err), 32'd0);
    chk("reset req_ready", 32'(bus.req_ready), 32'd0);
    chk("reset busy", 32'(bus.busy), 32'd0);

    // Single op, then advance the pointer back to requester 0 via req1
    cyc("add", 2'b01, 2'b11, ADD, 32'd5, 32'd7, ADD, 32'd0, 32'd0, 2'b01, mk(32'd12, 1'b0, 1'b0), NONE);
    cyc("idle1", 2'b00, 2'b11, ADD, 32'd0, 32'd0, ADD, 32'd0, 32'd0, 2'b00, NONE, NONE);
    cyc("or1", 2'b10, 2'b11, ADD, 32'd0, 32'd0, OR, 32'hF0, 32'h0F, 2'b10, NONE, mk(32'hFF, 1'b0, 1'b0));

    // Contention: grants alternate starting at requester 0
    for (int k = 0; k < 4; k++) begin
      cyc($sformatf("contend%0d", k), 2'b11, 2'b11, SUB, 32'd3, 32'd3, XOR, 32'hF0, 32'h0F,
          (k % 2 == 0) ? 2'b01 : 2'b10, mk(32'd0, 1'b1, 1'b0), mk(32'hFF, 1'b0, 1'b0));
    end

    // Backpressure on requester 1 while its buffer holds 0xFF
    cyc("bp_a", 2'b11, 2'b01, ADD, 32'd1, 32'd1, SRA, 32'h8000_0000, 32'd4, 2'b01, mk(32'd2, 1'b0, 1'b0), NONE);
    cyc("bp_b", 2'b11, 2'b01, ADD, 32'd1, 32'd1, SRA, 32'h8000_0000, 32'd4, 2'b01, mk(32'd2, 1'b0, 1'b0), NONE);
    chk("bp held valid1", 32'(bus.rsp_valid[1]), 32'd1);
    chk("bp held result1", bus.rsp_result[1], 32'hFF);
    cyc("bp_c", 2'b11, 2'b11, ADD, 32'd1, 32'd1, SRA, 32'h8000_0000, 32'd4, 2'b10, NONE, mk(32'hF800_0000, 1'b0, 1'b0));
    cyc("bp_idle", 2'b00, 2'b11, ADD, 32'd0, 32'd0, ADD, 32'd0, 32'd0, 2'b00, NONE, NONE);

    // Illegal encoding, then legal ops with drain+refill each cycle
    cyc("illegal", 2'b01, 2'b11, alu_t'(4'hF), 32'd1, 32'd2, ADD, 32'd0, 32'd0, 2'b01, mk(32'd0, 1'b1, 1'b1), NONE);
    cyc("clr_err", 2'b01, 2'b11, ADD, 32'd0, 32'd2, ADD, 32'd0, 32'd0, 2'b01, mk(32'd2, 1'b0, 1'b0), NONE);
    cyc("sltu", 2'b01, 2'b11, SLTU, 32'd1, 32'd2, ADD, 32'd0, 32'd0, 2'b01, mk(32'd1, 1'b0, 1'b0), NONE);
    cyc("hold", 2'b00, 2'b00, ADD, 32'd0, 32'd0, ADD, 32'd0, 32'd0, 2'b00, NONE, NONE);
    chk("refill valid", 32'(bus.rsp_valid), 32'd1);
    chk("refill result0", bus.rsp_result[0], 32'd1);
    cyc("drain", 2'b00, 2'b11, ADD, 32'd0, 32'd0, ADD, 32'd0, 32'd0, 2'b00, NONE, NONE);

    // Fill both buffers, then reset asynchronously mid-traffic
    cyc("fill1", 2'b11, 2'b00, SUB, 32'd9, 32'd4, AND, 32'hFF00, 32'h0FF0, 2'b10, NONE, mk(32'h0F00, 1'b0, 1'b0));
    cyc("fill0", 2'b11, 2'b00, SUB, 32'd9, 32'd4, AND, 32'hFF00, 32'h0FF0, 2'b01, mk(32'd5, 1'b0, 1'b0), NONE);
    chk("full valid", 32'(bus.rsp_valid), 32'd3);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async reset valid", 32'(bus.rsp_valid), 32'd0);
    chk("async reset result0", bus.rsp_result[0], 32'h0);
    chk("async reset result1", bus.rsp_result[1], 32'h0);
    q0.delete();
    q1.delete();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    cyc("post_rst", 2'b11, 2'b11, SUB, 32'd3, 32'd3, XOR, 32'hF0, 32'h0F, 2'b01, mk(32'd0, 1'b1, 1'b0), NONE);
    cyc("final", 2'b00, 2'b11, ADD, 32'd0, 32'd0, ADD, 32'd0, 32'd0, 2'b00, NONE, NONE);

    chk("q0 drained", 32'(q0.size()), 32'd0);
    chk("q1 drained", 32'(q1.size()), 32'd0);
    chk("end busy", 32'(bus.busy), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
